// File: rtl/seg_pkg.sv
// Shared 7-segment constants and codes for the display encoder
// and for the capture/monitor side.
package seg_pkg;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] CODE_BLANK = 4'hF;
   localparam logic [3:0] CODE_ERR   = 4'hE;

   typedef struct packed {
      logic [3:0] code;
      logic       is_blank;
      logic       is_err;
   } seg_dec_t;

endpackage

// File: rtl/seg_decode.sv
// Combinational inverse of the 7-segment encoder table:
// active-low segment pattern back to BCD, blank or error.
module seg_decode
   import seg_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] code,
   output logic       is_blank,
   output logic       is_err
);

   seg_dec_t w_dec;

   always_comb begin
      w_dec = '{code: CODE_ERR, is_blank: 1'b0, is_err: 1'b1};
      unique case (seg)
         SEG_0:     w_dec = '{4'd0, 1'b0, 1'b0};
         SEG_1:     w_dec = '{4'd1, 1'b0, 1'b0};
         SEG_2:     w_dec = '{4'd2, 1'b0, 1'b0};
         SEG_3:     w_dec = '{4'd3, 1'b0, 1'b0};
         SEG_4:     w_dec = '{4'd4, 1'b0, 1'b0};
         SEG_5:     w_dec = '{4'd5, 1'b0, 1'b0};
         SEG_6:     w_dec = '{4'd6, 1'b0, 1'b0};
         SEG_7:     w_dec = '{4'd7, 1'b0, 1'b0};
         SEG_8:     w_dec = '{4'd8, 1'b0, 1'b0};
         SEG_9:     w_dec = '{4'd9, 1'b0, 1'b0};
         SEG_BLANK: w_dec = '{CODE_BLANK, 1'b1, 1'b0};
         default:   w_dec = '{CODE_ERR, 1'b0, 1'b1};
      endcase
   end

   assign code     = w_dec.code;
   assign is_blank = w_dec.is_blank;
   assign is_err   = w_dec.is_err;

endmodule

// File: rtl/seg_capture.sv
// Passive monitor for a multiplexed active-low 7-segment bus:
// filters scan glitches, decodes digits and reports whole frames.
module seg_capture
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_DIGITS-1:0]   an,
   input  logic [6:0]              seg,
   output logic [4*NUM_DIGITS-1:0] value,
   output logic                    frame_valid,
   output logic                    frame_err,
   output logic [NUM_DIGITS-1:0]   blank_mask
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam int SW    = NUM_DIGITS + 7;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [SW-1:0]           w_smp;
   logic [SW-1:0]           r_sq;
   logic [CNT_W-1:0]        r_cnt;
   logic                    w_same;
   logic                    w_hit;

   logic [NUM_DIGITS-1:0]   w_sel;
   logic                    w_onehot;
   logic                    w_commit;
   logic                    w_done;

   logic [3:0]              w_code;
   logic                    w_is_blank;
   logic                    w_is_err;

   logic [4*NUM_DIGITS-1:0] r_store;
   logic [NUM_DIGITS-1:0]   r_seen;
   logic [NUM_DIGITS-1:0]   r_blank;
   logic                    r_err_acc;

   logic [4*NUM_DIGITS-1:0] w_store_nxt;
   logic [NUM_DIGITS-1:0]   w_seen_nxt;
   logic [NUM_DIGITS-1:0]   w_blank_nxt;
   logic                    w_err_nxt;

   logic [4*NUM_DIGITS-1:0] r_value;
   logic [NUM_DIGITS-1:0]   r_bmask;
   logic                    r_ferr;
   logic                    r_fv;

   assign w_smp  = {an, seg};
   assign w_same = (w_smp == r_sq);

   // Fires only on the edge that takes cnt to its saturation value
   assign w_hit = w_same && (r_cnt == (CNT_MAX - CNT_ONE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sq  <= '0;
         r_cnt <= '0;
      end else begin
         r_sq <= w_smp;
         if (w_same) begin
            if (r_cnt != CNT_MAX)
               r_cnt <= r_cnt + CNT_ONE;
         end else begin
            r_cnt <= CNT_ONE;
         end
      end
   end

   assign w_sel    = ~r_sq[SW-1:7];
   assign w_onehot = (w_sel != '0) &&
                     ((w_sel & (w_sel - NUM_DIGITS'(1))) == '0);
   assign w_commit = w_hit && w_onehot;

   seg_decode u_dec (
      .seg      (r_sq[6:0]),
      .code     (w_code),
      .is_blank (w_is_blank),
      .is_err   (w_is_err)
   );

   always_comb begin
      w_store_nxt = r_store;
      w_seen_nxt  = r_seen;
      w_blank_nxt = r_blank;
      w_err_nxt   = r_err_acc;
      if (w_commit) begin
         w_seen_nxt = r_seen | w_sel;
         w_err_nxt  = r_err_acc | w_is_err;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_sel[i]) begin
               w_store_nxt[4*i +: 4] = w_code;
               w_blank_nxt[i]        = w_is_blank;
            end
         end
      end
   end

   assign w_done = w_commit && (&w_seen_nxt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_store   <= '0;
         r_seen    <= '0;
         r_blank   <= '0;
         r_err_acc <= 1'b0;
         r_value   <= '0;
         r_bmask   <= '0;
         r_ferr    <= 1'b0;
         r_fv      <= 1'b0;
      end else begin
         r_fv    <= w_done;
         r_store <= w_store_nxt;
         if (w_done) begin
            r_value   <= w_store_nxt;
            r_bmask   <= w_blank_nxt;
            r_ferr    <= w_err_nxt;
            r_seen    <= '0;
            r_blank   <= '0;
            r_err_acc <= 1'b0;
         end else begin
            r_seen    <= w_seen_nxt;
            r_blank   <= w_blank_nxt;
            r_err_acc <= w_err_nxt;
         end
      end
   end

   assign value       = r_value;
   assign blank_mask  = r_bmask;
   assign frame_err   = r_ferr;
   assign frame_valid = r_fv;

endmodule

// File: tb/tb_seg_capture.sv
// Directed self-checking bench for seg_capture
// (NUM_DIGITS=4, STABLE_CYCLES=4).
module tb_seg_capture;

   logic        clk;
   logic        rst;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic [15:0] value;
   logic        frame_valid;
   logic        frame_err;
   logic [3:0]  blank_mask;

   int checks   = 0;
   int failures = 0;
   int fv_cnt   = 0;
   int base;

   localparam logic [6:0] P0 = 7'b1000000;
   localparam logic [6:0] P1 = 7'b1111001;
   localparam logic [6:0] P2 = 7'b0100100;
   localparam logic [6:0] P3 = 7'b0110000;
   localparam logic [6:0] P4 = 7'b0011001;
   localparam logic [6:0] P5 = 7'b0010010;
   localparam logic [6:0] P6 = 7'b0000010;
   localparam logic [6:0] P7 = 7'b1111000;
   localparam logic [6:0] P8 = 7'b0000000;
   localparam logic [6:0] P9 = 7'b0010000;
   localparam logic [6:0] PB = 7'b1111111;
   localparam logic [6:0] PX = 7'b1010101;

   seg_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .an          (an),
      .seg         (seg),
      .value       (value),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .blank_mask  (blank_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk)
      if (frame_valid === 1'b1) fv_cnt++;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input logic [3:0] a,
                       input logic [6:0] s,
                       input int n);
      an  = a;
      seg = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic idle(input int n);
      hold(4'b1111, PB, n);
   endtask

   initial begin
      rst = 1'b1;
      an  = 4'b1111;
      seg = PB;
      repeat (3) @(negedge clk);
      check("rst_value", 32'(value), 32'h0);
      check("rst_fv", 32'(frame_valid), 32'h0);
      check("rst_err", 32'(frame_err), 32'h0);
      check("rst_blank", 32'(blank_mask), 32'h0);
      rst = 1'b0;
      idle(2);

      // Basic scan 1,2,3,4 with commit latency probe on digit 3
      base = fv_cnt;
      hold(4'b1110, P1, 8);
      hold(4'b1101, P2, 8);
      hold(4'b1011, P3, 8);
      hold(4'b0111, P4, 3);
      check("lat_fv_before", 32'(frame_valid), 32'h0);
      @(negedge clk);
      check("lat_fv_pulse", 32'(frame_valid), 32'h1);
      check("f1_value", 32'(value), 32'h4321);
      @(negedge clk);
      check("lat_fv_after", 32'(frame_valid), 32'h0);
      repeat (3) @(negedge clk);
      idle(3);
      check("f1_count", 32'(fv_cnt - base), 32'd1);
      check("f1_err", 32'(frame_err), 32'h0);
      check("f1_blank", 32'(blank_mask), 32'h0);

      // Too-short holds never commit; four cycles is enough
      base = fv_cnt;
      hold(4'b1110, P1, 3);
      hold(4'b1101, P2, 3);
      hold(4'b1011, P3, 3);
      hold(4'b0111, P4, 3);
      idle(3);
      check("short_count", 32'(fv_cnt - base), 32'd0);
      hold(4'b1110, P1, 4);
      hold(4'b1101, P2, 4);
      hold(4'b1011, P3, 4);
      hold(4'b0111, P4, 4);
      idle(3);
      check("exact_count", 32'(fv_cnt - base), 32'd1);
      check("exact_value", 32'(value), 32'h4321);

      // Blank on digit 2, error on digit 1
      base = fv_cnt;
      hold(4'b1110, P6, 8);
      hold(4'b1101, PX, 8);
      hold(4'b1011, PB, 8);
      hold(4'b0111, P5, 8);
      idle(3);
      check("be_count", 32'(fv_cnt - base), 32'd1);
      check("be_value", 32'(value), 32'h5FE6);
      check("be_blank", 32'(blank_mask), 32'b0100);
      check("be_err", 32'(frame_err), 32'h1);
      hold(4'b1110, P8, 6);
      hold(4'b1101, P7, 6);
      hold(4'b1011, P6, 6);
      hold(4'b0111, P5, 6);
      idle(3);
      check("clean_count", 32'(fv_cnt - base), 32'd2);
      check("clean_value", 32'(value), 32'h5678);
      check("clean_err", 32'(frame_err), 32'h0);
      check("clean_blank", 32'(blank_mask), 32'h0);

      // Display off and multi-low anodes mid-scan
      base = fv_cnt;
      hold(4'b1110, P9, 8);
      hold(4'b1101, P8, 8);
      hold(4'b1111, P3, 20);
      hold(4'b1100, P8, 20);
      idle(3);
      check("off_count", 32'(fv_cnt - base), 32'd0);
      check("off_value", 32'(value), 32'h5678);
      hold(4'b1110, P0, 8);
      hold(4'b1101, P5, 8);
      hold(4'b1011, P7, 8);
      hold(4'b0111, P9, 8);
      idle(3);
      check("resume_count", 32'(fv_cnt - base), 32'd1);
      check("resume_value", 32'(value), 32'h9750);

      // Revisit of digit 0: latest value wins
      base = fv_cnt;
      hold(4'b1110, P7, 8);
      hold(4'b1110, P9, 8);
      hold(4'b1101, P2, 8);
      hold(4'b1011, P3, 8);
      hold(4'b0111, P6, 8);
      idle(3);
      check("rev_count", 32'(fv_cnt - base), 32'd1);
      check("rev_digit0", 32'(value[3:0]), 32'h9);
      check("rev_value", 32'(value), 32'h6329);

      // Reset mid-frame discards the partial frame
      base = fv_cnt;
      hold(4'b1110, P1, 8);
      hold(4'b1101, P1, 8);
      hold(4'b1011, P1, 8);
      rst = 1'b1;
      idle(2);
      check("mid_rst_value", 32'(value), 32'h0);
      rst = 1'b0;
      idle(2);
      hold(4'b0111, P1, 8);
      idle(3);
      check("post_rst_count", 32'(fv_cnt - base), 32'd0);
      check("post_rst_value", 32'(value), 32'h0);
      check("post_rst_blank", 32'(blank_mask), 32'h0);
      check("post_rst_err", 32'(frame_err), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
